uart_cmd_parser: RTL

//  Downstream of the UART receiver: consumes received bytes (rx_data/rx_done) and parses ASCII

---
 rtl/uart_cmd_parser.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_parser.sv
// ASCII command-line parser behind a UART receiver: decimal+EOL -> SET, R/S/C -> RUN/STOP/CLR.
// Optional idle timeout on partial lines when CMD_TIMEOUT_EN is defined.
module uart_cmd_parser #(
   parameter int MAX_DIGITS     = 4,
   parameter int VALUE_W        = 14,
   parameter int TIMEOUT_CYCLES = 10_000_000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         rx_data,
   input  logic               rx_done,
   output logic               cmd_valid,
   output logic [1:0]         cmd_code,
   output logic [VALUE_W-1:0] cmd_value,
   output logic               cmd_err,
   output logic [1:0]         dbg_state_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_NUM  = 2'd1;
   localparam logic [1:0] S_ERR  = 2'd2;

   localparam logic [1:0] C_SET  = 2'd0;
   localparam logic [1:0] C_RUN  = 2'd1;
   localparam logic [1:0] C_STOP = 2'd2;
   localparam logic [1:0] C_CLR  = 2'd3;

   localparam int ND_W = $clog2(MAX_DIGITS + 1);

   logic [1:0]         state_q, state_d;
   logic [VALUE_W-1:0] acc_q, acc_d;
   logic [ND_W-1:0]    ndig_q, ndig_d;
   logic               valid_q, valid_d;
   logic               err_q, err_d;
   logic [1:0]         code_q, code_d;
   logic [VALUE_W-1:0] value_q, value_d;

   logic               is_digit, is_eol;
   logic [7:0]         lower;
   logic [VALUE_W-1:0] digit_val;
   logic               timeout;

   assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign is_eol    = (rx_data == 8'h0D) || (rx_data == 8'h0A);
   // Folding bit 5 maps upper-case letters onto lower-case for the R/S/C match.
   assign lower     = rx_data | 8'h20;
   assign digit_val = {{(VALUE_W-4){1'b0}}, rx_data[3:0]};

`ifdef CMD_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign timeout = !rx_done && (state_q != S_IDLE) &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (rx_done || (state_q == S_IDLE) || timeout) cnt_d = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
   assign timeout        = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ndig_d  = ndig_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      code_d  = code_q;
      value_d = value_q;
      if (rx_done) begin
         case (state_q)
            S_IDLE: begin
               if (is_digit) begin
                  acc_d   = digit_val;
                  ndig_d  = ND_W'(1);
                  state_d = S_NUM;
               end else if (lower == 8'h72) begin
                  valid_d = 1'b1;
                  code_d  = C_RUN;
               end else if (lower == 8'h73) begin
                  valid_d = 1'b1;
                  code_d  = C_STOP;
               end else if (lower == 8'h63) begin
                  valid_d = 1'b1;
                  code_d  = C_CLR;
               end
            end
            S_NUM: begin
               if (is_digit && (ndig_q < ND_W'(MAX_DIGITS))) begin
                  acc_d  = (acc_q << 3) + (acc_q << 1) + digit_val;
                  ndig_d = ndig_q + ND_W'(1);
               end else if (is_eol) begin
                  valid_d = 1'b1;
                  code_d  = C_SET;
                  value_d = acc_q;
                  acc_d   = '0;
                  ndig_d  = '0;
                  state_d = S_IDLE;
               end else begin
                  // Too many digits or any non-digit: reject the rest of the line.
                  err_d   = 1'b1;
                  state_d = S_ERR;
               end
            end
            S_ERR: begin
               if (is_eol) begin
                  acc_d   = '0;
                  ndig_d  = '0;
                  state_d = S_IDLE;
               end
            end
            default: begin
               acc_d   = '0;
               ndig_d  = '0;
               state_d = S_IDLE;
            end
         endcase
      end else if (timeout) begin
         err_d   = (state_q == S_NUM);
         acc_d   = '0;
         ndig_d  = '0;
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         ndig_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= C_SET;
         value_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ndig_q  <= ndig_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         code_q  <= code_d;
         value_q <= value_d;
      end
   end

   assign cmd_valid   = valid_q;
   assign cmd_err     = err_q;
   assign cmd_code    = code_q;
   assign cmd_value   = value_q;
   assign dbg_state_o = state_q;

endmodule
